// File: rtl/datapath_core_pkg.sv
// Shared constants for the datapath: control-word bit positions, flag positions,
// default widths and the one-hot ALU operation encoding.
package datapath_core_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned CTRL_W     = 32;

  localparam int unsigned CTRL_CU0      = 0;
  localparam int unsigned CTRL_CU1      = 1;
  localparam int unsigned CTRL_CU2      = 2;
  localparam int unsigned CTRL_MEM_RD   = 3;
  localparam int unsigned CTRL_IR_LD    = 4;
  localparam int unsigned CTRL_MAR_MBR  = 5;
  localparam int unsigned CTRL_PC_INC   = 6;
  localparam int unsigned CTRL_BR_LD    = 7;
  localparam int unsigned CTRL_ACC_CLR  = 8;
  localparam int unsigned CTRL_ADD      = 9;
  localparam int unsigned CTRL_MAR_PC   = 10;
  localparam int unsigned CTRL_MEM_WR   = 11;
  localparam int unsigned CTRL_MBR_ACC  = 12;
  localparam int unsigned CTRL_SUB      = 13;
  localparam int unsigned CTRL_PC_MBR   = 14;
  localparam int unsigned CTRL_MUL      = 15;
  localparam int unsigned CTRL_DIV      = 16;
  localparam int unsigned CTRL_SHL      = 17;
  localparam int unsigned CTRL_SHR      = 18;
  localparam int unsigned CTRL_AND      = 19;
  localparam int unsigned CTRL_OR       = 20;
  localparam int unsigned CTRL_NOT      = 21;

  localparam int unsigned FLAG_ZF = 3;
  localparam int unsigned FLAG_CF = 2;
  localparam int unsigned FLAG_OF = 1;
  localparam int unsigned FLAG_SF = 0;

  // ALU op vector, ordered so that bit 0 is the lowest-numbered control bit.
  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_MUL = 2;
  localparam int unsigned ALU_DIV = 3;
  localparam int unsigned ALU_SHL = 4;
  localparam int unsigned ALU_SHR = 5;
  localparam int unsigned ALU_AND = 6;
  localparam int unsigned ALU_OR  = 7;
  localparam int unsigned ALU_NOT = 8;
  localparam int unsigned ALU_OPS = 9;

  typedef logic [ALU_OPS-1:0] alu_op_t;

  function automatic alu_op_t alu_req(input logic [CTRL_W-1:0] ctrl);
    return {ctrl[CTRL_NOT:CTRL_MUL], ctrl[CTRL_SUB], ctrl[CTRL_ADD]};
  endfunction

endpackage

// File: rtl/datapath_core_if.sv
// Control-word and main-memory bus between the control unit/memory (master)
// and the datapath (slave).
interface datapath_core_if
  import datapath_core_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output ctrl, mem_rdata,
    input  mem_addr, mem_rd, mem_we, mem_wdata
  );

  modport slave (
    input  ctrl, mem_rdata,
    output mem_addr, mem_rd, mem_we, mem_wdata
  );
endinterface

// File: rtl/datapath_core_alu_core.sv
// Combinational ALU: one-hot op in, result and {ZF, CF, OF, SF} out.
module alu_core
  import datapath_core_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_br,
  input  alu_op_t           i_op,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_flags,
  output logic              o_result_valid
);
  localparam int unsigned MSB = DATA_W - 1;

  logic [DATA_W:0]     w_sum, w_diff, w_shl, w_shr;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_den, w_quot, w_res;
  logic [4:0]          w_amt;
  logic                w_div_zero, w_div_ovf, w_cf, w_of;

  assign w_sum  = {1'b0, i_acc} + {1'b0, i_br};
  assign w_diff = {1'b0, i_acc} - {1'b0, i_br};
  assign w_prod = $signed(i_acc) * $signed(i_br);

  assign w_div_zero = (i_br == '0);
  assign w_div_ovf  = (i_acc == {1'b1, {(DATA_W-1){1'b0}}}) && (&i_br);
  assign w_den      = w_div_zero ? {{(DATA_W-1){1'b0}}, 1'b1} : i_br;
  assign w_quot     = $signed(i_acc) / $signed(w_den);

  // The extra bit catches the last bit shifted out; amounts past DATA_W leave it 0.
  assign w_amt = i_br[4:0];
  assign w_shl = {1'b0, i_acc} << w_amt;
  assign w_shr = {i_acc, 1'b0} >> w_amt;

  always_comb begin
    w_res = i_acc;
    w_cf  = 1'b0;
    w_of  = 1'b0;
    unique case (1'b1)
      i_op[ALU_ADD]: begin
        w_res = w_sum[MSB:0];
        w_cf  = w_sum[DATA_W];
        w_of  = (i_acc[MSB] == i_br[MSB]) && (w_sum[MSB] != i_acc[MSB]);
      end
      i_op[ALU_SUB]: begin
        w_res = w_diff[MSB:0];
        w_cf  = w_diff[DATA_W];
        w_of  = (i_acc[MSB] != i_br[MSB]) && (w_diff[MSB] != i_acc[MSB]);
      end
      i_op[ALU_MUL]: begin
        w_res = w_prod[MSB:0];
        w_of  = (w_prod[2*DATA_W-1:DATA_W] != {DATA_W{w_prod[MSB]}});
      end
      i_op[ALU_DIV]: begin
        if (w_div_zero) begin
          w_of = 1'b1;
        end else if (w_div_ovf) begin
          w_res = i_acc;
          w_of  = 1'b1;
        end else begin
          w_res = w_quot;
        end
      end
      i_op[ALU_SHL]: begin
        w_res = w_shl[MSB:0];
        w_cf  = w_shl[DATA_W];
      end
      i_op[ALU_SHR]: begin
        w_res = w_shr[DATA_W:1];
        w_cf  = w_shr[0];
      end
      i_op[ALU_AND]: w_res = i_acc & i_br;
      i_op[ALU_OR]:  w_res = i_acc | i_br;
      i_op[ALU_NOT]: w_res = ~i_br;
      default: ;
    endcase
  end

  always_comb begin
    o_flags          = '0;
    o_flags[FLAG_ZF] = (w_res == '0);
    o_flags[FLAG_CF] = w_cf;
    o_flags[FLAG_OF] = w_of;
    o_flags[FLAG_SF] = w_res[MSB];
  end

  assign o_result       = w_res;
  assign o_result_valid = |i_op;

endmodule

// File: rtl/datapath_core.sv
// Register-transfer datapath driven one control word per cycle by the
// microprogrammed control unit; owns PC, MAR, MBR, IR, BR, ACC and the flags.
module datapath_core
  import datapath_core_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  datapath_core_if.slave    bus,
  output logic [7:0]        IR_out,
  output logic [3:0]        ALUflags,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ctrl_err
);
  logic [ADDR_W-1:0] r_pc, r_mar, w_pc_d, w_mar_d;
  logic [DATA_W-1:0] r_mbr, r_br, r_acc, w_mbr_d, w_br_d, w_acc_d;
  logic [7:0]        r_ir, w_ir_d;
  logic [3:0]        r_flags, w_flags_d, w_alu_flags;
  logic              r_ctrl_err, w_conflict;
  logic [CTRL_W-1:0] w_c;
  alu_op_t           w_alu_req, w_alu_op;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_valid, w_alu_multi;
  logic              w_unused_ctrl;

  assign w_c           = bus.ctrl;
  assign w_unused_ctrl = ^{w_c[CTRL_CU2:CTRL_CU0], w_c[CTRL_W-1:CTRL_NOT+1]};

  // Lowest-numbered requested op wins; C8 suppresses the ALU entirely.
  assign w_alu_req   = w_c[CTRL_ACC_CLR] ? '0 : alu_req(w_c);
  assign w_alu_op    = w_alu_req & (~w_alu_req + 1'b1);
  assign w_alu_multi = (w_alu_req & (w_alu_req - 1'b1)) != '0;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_acc          (r_acc),
    .i_br           (r_br),
    .i_op           (w_alu_op),
    .o_result       (w_alu_res),
    .o_flags        (w_alu_flags),
    .o_result_valid (w_alu_valid)
  );

  always_comb begin
    w_mbr_d   = r_mbr;
    w_mar_d   = r_mar;
    w_pc_d    = r_pc;
    w_ir_d    = r_ir;
    w_br_d    = r_br;
    w_acc_d   = r_acc;
    w_flags_d = r_flags;

    if (w_c[CTRL_MBR_ACC])     w_mbr_d = r_acc;
    else if (w_c[CTRL_MEM_RD]) w_mbr_d = bus.mem_rdata;

    if (w_c[CTRL_MAR_PC])       w_mar_d = r_pc;
    else if (w_c[CTRL_MAR_MBR]) w_mar_d = r_mbr[ADDR_W-1:0];

    if (w_c[CTRL_PC_MBR])      w_pc_d = r_mbr[ADDR_W-1:0];
    else if (w_c[CTRL_PC_INC]) w_pc_d = r_pc + 1'b1;

    if (w_c[CTRL_IR_LD]) w_ir_d = r_mbr[DATA_W-1 -: 8];
    if (w_c[CTRL_BR_LD]) w_br_d = r_mbr;

    if (w_c[CTRL_ACC_CLR]) begin
      w_acc_d = '0;
    end else if (w_alu_valid) begin
      w_acc_d   = w_alu_res;
      w_flags_d = w_alu_flags;
    end
  end

  assign w_conflict = (w_c[CTRL_MEM_RD]  & w_c[CTRL_MBR_ACC]) |
                      (w_c[CTRL_MAR_MBR] & w_c[CTRL_MAR_PC])  |
                      (w_c[CTRL_PC_INC]  & w_c[CTRL_PC_MBR])  |
                      w_alu_multi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_mar      <= '0;
      r_mbr      <= '0;
      r_ir       <= '0;
      r_br       <= '0;
      r_acc      <= '0;
      r_flags    <= '0;
      r_ctrl_err <= 1'b0;
    end else begin
      r_pc       <= w_pc_d;
      r_mar      <= w_mar_d;
      r_mbr      <= w_mbr_d;
      r_ir       <= w_ir_d;
      r_br       <= w_br_d;
      r_acc      <= w_acc_d;
      r_flags    <= w_flags_d;
      r_ctrl_err <= r_ctrl_err | w_conflict;
    end
  end

  assign bus.mem_addr  = r_mar;
  assign bus.mem_wdata = r_mbr;
  assign bus.mem_rd    = w_c[CTRL_MEM_RD];
  assign bus.mem_we    = w_c[CTRL_MEM_WR];

  assign IR_out   = r_ir;
  assign ALUflags = r_flags;
  assign acc_out  = r_acc;
  assign pc_out   = r_pc;
  assign ctrl_err = r_ctrl_err;

endmodule

// File: doc/datapath_core.md
# datapath_core

Register-transfer datapath executed by the microprogrammed control unit. Each cycle it consumes the 32-bit control word (C0–C31) and performs the selected transfers among PC, MAR, MBR, IR, BR and ACC, plus the main-memory read/write. It returns the opcode register and ALU flags to the control unit. It is the consumer end of the control-word interface.

## Interface
- DATA_W, 16: width of MBR, BR, ACC, memory data.
- ADDR_W, 8: width of PC, MAR, memory address.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ctrl  in  32  control word C0..C31 (bit n = Cn).
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr.
- mem_addr  out  ADDR_W  always equals MAR.
- mem_rd  out  1  equals C3.
- mem_we  out  1  equals C11.
- mem_wdata  out  DATA_W  always equals MBR.
- IR_out  out  8  instruction opcode register.
- ALUflags  out  4  registered {ZF, CF, OF, SF}.
- acc_out  out  DATA_W  ACC, for debug and display.
- pc_out  out  ADDR_W  PC, for debug.
- ctrl_err  out  1  sticky; set on any conflicting control word.

## Operation
- All transfers use pre-edge register values and commit on one rising edge. C5|C6 therefore loads MAR from the old MBR and increments PC in the same cycle.
- C0–C2 are ignored here; they belong to the control unit.
- C3: MBR <- mem_rdata.
- C4: IR <- MBR[15:8].
- C5: MAR <- MBR[7:0].
- C6: PC <- PC+1, wrapping 0xFF->0x00.
- C7: BR <- MBR.
- C10: MAR <- PC.
- C11: memory write of the current MBR. With C11|C12 in one word, memory receives the old MBR.
- C12: MBR <- ACC.
- C14: PC <- MBR[7:0].
- Write-port conflicts, with the winner and ctrl_err set for the cycle:
  - MBR: C3+C12, C12 wins.
  - MAR: C5+C10, C10 wins.
  - PC: C6+C14, C14 wins.
- ACC ops:
  - C8 clears ACC. C8 overrides any ALU op in the same word, ctrl_err is not set, and flags are unchanged.
  - ALU ops are C9, C13, C15–C21. If more than one is asserted, the lowest-numbered op executes and ctrl_err is set.
- Arithmetic, all two's complement, ACC truncated to DATA_W:
  - C9 add: CF = unsigned carry out. OF = signed overflow.
  - C13 subtract: CF = borrow (ACC <u BR). OF = signed overflow.
  - C15 multiply: signed product, low half kept. OF = 1 when the high half is not the sign extension of the low half. CF = 0.
  - C16 divide: signed quotient truncated toward zero.
    - BR=0: ACC unchanged, OF=1.
    - 0x8000/0xFFFF: ACC=0x8000, OF=1.
  - C17/C18 shift left / logical right:
    - Shift amount is BR[4:0]. An amount of 16 or more gives 0.
    - CF = last bit shifted out, 0 for an amount of 0.
  - C19 AND, C20 OR, C21 ACC <- ~BR: CF=OF=0.
- ZF and SF are computed from the new ACC on every executed ALU op. Flags hold in every other cycle.

## Timing
- Reset values: all registers (PC, MAR, MBR, IR, BR, ACC, flags) = 0 and ctrl_err = 0.
- mem_rd, mem_we, mem_addr and mem_wdata are combinational from ctrl, MAR and MBR. After reset, mem_addr = 0 and mem_wdata = 0.
- Latency: a transfer commanded in ctrl during cycle n is visible on outputs after edge n.
- The control unit registers its word, so the datapath never sees ctrl and its own result in the same cycle. No stall path exists.
- Reset asserted mid-instruction clears everything immediately. A pending write is dropped only if reset is asserted before the edge.
- ctrl_err clears only on reset.

## Structure
- Shared package/header holds:
  - control-bit indices (CTRL_* 0..21);
  - flag positions (FLAG_ZF=3, FLAG_CF=2, FLAG_OF=1, FLAG_SF=0);
  - DATA_W/ADDR_W defaults.
- Opcodes stay in instruction_set.vh.
- One sub-module, alu_core: combinational; inputs acc, br and a one-hot op; outputs result, flags and result_valid.
- Registers and priority logic live in datapath_core.

## Test plan
- Reset mid-run with all registers nonzero -> all outputs 0 and ctrl_err=0 while rst_n is low.
- Fetch sequence:
  - Setup: mem[0]=0x0205.
  - Stimulus: C3, then C4, then C5|C6.
  - Expected: IR_out=0x02, MAR=0x05, PC=0x01, mem_addr=0x05.
- Add overflow: ACC=0x7FFF, BR=0x0001, C9 -> ACC=0x8000, flags SF=1, OF=1, CF=0, ZF=0.
- Subtract borrow then zero: ACC=0x0003, BR=0x0005, C13 -> ACC=0xFFFE, CF=1, SF=1; then ACC=BR=5, C13 -> ZF=1.
- Multiply overflow and divide by zero:
  - ACC=0x0100, BR=0x0100, C15 -> ACC=0x0000, OF=1, ZF=1.
  - ACC=7, BR=0, C16 -> ACC=7, OF=1.
- Conflicts and store:
  - C3|C12 with ACC=0x1234 -> MBR=0x1234, ctrl_err=1 and stays 1.
  - C11|C12 -> mem_we=1 with the old MBR on mem_wdata.
